matmul_bus_master: RTL and testbench

Synthesizable, parametrised matrix-multiply bus master: computes AB = A × B for signed N×N matrices held in memory, issuing single-word reads/writes over the cpu-side rd/wr/ready bus into the cache/memory hierarchy. It replaces behavioural CPU traffic generators as a cycle-accurate load for cache validation, with a runtime-configurable base-address and result mode, a bus timeout and a done/err status.

---
 rtl/matmul_bus_master.sv | 237 +++++++++++++++++++++++
 tb/tb_matmul_bus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_bus_master.sv
// ---------------------------------------------------------------------------
// matmul_bus_master
//
// Bus master that computes AB = A x B for signed N x N matrices held in
// word-addressed memory. It issues one single-word read or write at a time
// over a rd/wr/ready bus. Matrices are row-major: element (r,c) of a matrix
// lives at base + N*r + c. Address arithmetic wraps modulo 2^ADR_WIDTH.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle request to begin (ignored while busy)
//   base_a/base_b/base_ab word base addresses, latched on accepted start
//   sat_mode             0 = wrap result to DATA_WIDTH bits, 1 = saturate
//   busy, done, err      status: running, completion pulse, sticky timeout
//   address_bus          request address, high-Z when no request
//   data_bus             bidirectional data, driven only during writes
//   ready                memory handshake; transfer on rising edge with ready
//   rd, wr               read / write request strobes (never both high)
// ---------------------------------------------------------------------------
module matmul_bus_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 16,
    parameter int N          = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADR_WIDTH-1:0]  base_a,
    input  logic [ADR_WIDTH-1:0]  base_b,
    input  logic [ADR_WIDTH-1:0]  base_ab,
    input  logic                  sat_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADR_WIDTH-1:0]  address_bus,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  ready,
    output logic                  rd,
    output logic                  wr
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // Clamp limits expressed at accumulator width for signed comparison.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_GAP_A, S_RD_B, S_MAC, S_WR, S_GAP_W, S_DONE
    } state_t;

    state_t                         r_state, w_state_next;
    logic [ADR_WIDTH-1:0]           r_base_a, r_base_b, r_base_ab;
    logic [ADR_WIDTH-1:0]           w_base_a_next, w_base_b_next, w_base_ab_next;
    logic                           r_sat, w_sat_next;
    logic                           r_err, w_err_next;
    logic [IW-1:0]                  r_i, r_j, r_k, w_i_next, w_j_next, w_k_next;
    logic signed [ACC_WIDTH-1:0]    r_acc, w_acc_next;
    logic signed [DATA_WIDTH-1:0]   r_a, r_b, w_a_next, w_b_next;
    logic [TW-1:0]                  r_to, w_to_next;
    logic                           r_rd, r_wr, w_rd_next, w_wr_next;
    logic [ADR_WIDTH-1:0]           r_addr, w_addr_next;
    logic [DATA_WIDTH-1:0]          r_wdata, w_wdata_next;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]          w_result;

    assign w_prod = r_a * r_b;

    // Next-state and datapath updates.
    always_comb begin
        w_state_next   = r_state;
        w_base_a_next  = r_base_a;
        w_base_b_next  = r_base_b;
        w_base_ab_next = r_base_ab;
        w_sat_next     = r_sat;
        w_err_next     = r_err;
        w_i_next       = r_i;
        w_j_next       = r_j;
        w_k_next       = r_k;
        w_acc_next     = r_acc;
        w_a_next       = r_a;
        w_b_next       = r_b;
        w_to_next      = r_to;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_a_next  = base_a;
                    w_base_b_next  = base_b;
                    w_base_ab_next = base_ab;
                    w_sat_next     = sat_mode;
                    w_err_next     = 1'b0;
                    w_i_next       = '0;
                    w_j_next       = '0;
                    w_k_next       = '0;
                    w_acc_next     = '0;
                    w_state_next   = S_RD_A;
                end
            end
            S_RD_A, S_RD_B, S_WR: begin
                if (ready) begin
                    if (r_state == S_RD_A) begin
                        w_a_next     = data_bus;
                        w_state_next = S_GAP_A;
                    end else if (r_state == S_RD_B) begin
                        w_b_next     = data_bus;
                        w_state_next = S_MAC;
                    end else begin
                        w_state_next = S_GAP_W;
                    end
                end else if (r_to == TW'(TIMEOUT - 1)) begin
                    // Abort: the request is dropped on the same edge.
                    w_err_next   = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_to_next = r_to + TW'(1);
                end
            end
            S_GAP_A: w_state_next = S_RD_B;
            S_MAC: begin
                w_acc_next = r_acc + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
                if (r_k == IW'(N - 1)) begin
                    w_state_next = S_WR;
                end else begin
                    w_k_next     = r_k + IW'(1);
                    w_state_next = S_RD_A;
                end
            end
            S_GAP_W: begin
                w_acc_next   = '0;
                w_k_next     = '0;
                w_state_next = S_RD_A;
                if (r_j == IW'(N - 1)) begin
                    w_j_next = '0;
                    if (r_i == IW'(N - 1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_i_next = r_i + IW'(1);
                    end
                end else begin
                    w_j_next = r_j + IW'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Wait counter restarts whenever a new request state is entered.
        if (w_state_next != r_state) begin
            w_to_next = '0;
        end
    end

    // Result formatting of the accumulator value that will be written.
    always_comb begin
        w_result = w_acc_next[DATA_WIDTH-1:0];
        if (w_sat_next) begin
            if (w_acc_next > SAT_MAX) begin
                w_result = SAT_MAX[DATA_WIDTH-1:0];
            end else if (w_acc_next < SAT_MIN) begin
                w_result = SAT_MIN[DATA_WIDTH-1:0];
            end
        end
    end

    // Bus outputs are computed from the next state so they leave a register.
    always_comb begin
        w_rd_next    = (w_state_next == S_RD_A) || (w_state_next == S_RD_B);
        w_wr_next    = (w_state_next == S_WR);
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        case (w_state_next)
            S_RD_A: w_addr_next = w_base_a_next + ADR_WIDTH'(N) * ADR_WIDTH'(w_i_next)
                                  + ADR_WIDTH'(w_k_next);
            S_RD_B: w_addr_next = w_base_b_next + ADR_WIDTH'(N) * ADR_WIDTH'(w_k_next)
                                  + ADR_WIDTH'(w_j_next);
            S_WR: begin
                w_addr_next  = w_base_ab_next + ADR_WIDTH'(N) * ADR_WIDTH'(w_i_next)
                               + ADR_WIDTH'(w_j_next);
                w_wdata_next = w_result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base_a  <= '0;
            r_base_b  <= '0;
            r_base_ab <= '0;
            r_sat     <= 1'b0;
            r_err     <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_to      <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_base_a  <= w_base_a_next;
            r_base_b  <= w_base_b_next;
            r_base_ab <= w_base_ab_next;
            r_sat     <= w_sat_next;
            r_err     <= w_err_next;
            r_i       <= w_i_next;
            r_j       <= w_j_next;
            r_k       <= w_k_next;
            r_acc     <= w_acc_next;
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_to      <= w_to_next;
            r_rd      <= w_rd_next;
            r_wr      <= w_wr_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = r_err;
    assign rd          = r_rd;
    assign wr          = r_wr;
    assign address_bus = (r_rd || r_wr) ? r_addr : {ADR_WIDTH{1'bz}};
    assign data_bus    = r_wr ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_matmul_bus_master.sv
// ---------------------------------------------------------------------------
// Testbench for matmul_bus_master (N = 4). A word memory with optional random
// wait states answers the bus. Each job pushes its expected bus transactions
// (read addresses and written results, derived from plain matrix arithmetic)
// into a queue; a monitor pops and compares every completed transfer.
// ---------------------------------------------------------------------------
module tb_matmul_bus_master;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int N  = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_a = '0, base_b = '0, base_ab = '0;
    logic          sat_mode = 1'b0;
    logic          busy, done, err, rd, wr, ready;
    wire  [AW-1:0] address_bus;
    wire  [DW-1:0] data_bus;

    matmul_bus_master #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .N(N), .ACC_WIDTH(40), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_a(base_a), .base_b(base_b), .base_ab(base_ab),
        .sat_mode(sat_mode), .busy(busy), .done(done), .err(err),
        .address_bus(address_bus), .data_bus(data_bus),
        .ready(ready), .rd(rd), .wr(wr)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem [0:65535];
    logic [15:0] rd_word;
    int          wcnt = 0;
    int          cur_wait = 0;
    bit          stall = 1'b0;
    bit          rand_wait = 1'b0;

    assign rd_word  = mem[address_bus];
    assign data_bus = rd ? rd_word : 16'hzzzz;
    assign ready    = (rd || wr) && !stall && (wcnt >= cur_wait);

    always @(posedge clk) begin
        if (rd || wr) begin
            if (ready) begin
                if (wr) mem[address_bus] = data_bus;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt     <= 0;
            cur_wait <= rand_wait ? int'($urandom_range(3, 0)) : 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   waits = 0;
    int   proto_errs = 0;
    bit   xfer_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        txn_t e;
        if (!rst) begin
            if ((rd || wr) && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_txn: got wr=%0d addr=0x%0h, expected none", wr, address_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_kind", longint'(wr), longint'(e.is_wr));
                    check("txn_addr", longint'(address_bus), longint'(e.addr));
                    if (e.is_wr) check("txn_data", longint'(data_bus), longint'(e.data));
                end
            end
            if ((rd || wr) && !ready) waits++;
            if ((rd || wr) && xfer_prev) proto_errs++;
            if (rd && wr) proto_errs++;
            xfer_prev = (rd || wr) && ready;
        end else begin
            xfer_prev = 1'b0;
        end
    end

    // Reference model: plain matrix product with wrap or clamp.
    task automatic push_expected(input logic [15:0] ba, input logic [15:0] bb,
                                 input logic [15:0] bab, input bit sat);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint acc = 0;
                logic [15:0] res;
                for (int k = 0; k < N; k++) begin
                    logic [15:0] aa, ab;
                    aa = ba + 16'(N * i + k);
                    ab = bb + 16'(N * k + j);
                    exp_q.push_back('{1'b0, aa, 16'h0});
                    exp_q.push_back('{1'b0, ab, 16'h0});
                    acc += longint'($signed(mem[aa])) * longint'($signed(mem[ab]));
                end
                if (sat && acc > 32767)        res = 16'h7FFF;
                else if (sat && acc < -32768)  res = 16'h8000;
                else                           res = 16'(acc);
                exp_q.push_back('{1'b1, bab + 16'(N * i + j), res});
            end
        end
    endtask

    task automatic fill(input logic [15:0] base, input bit use_const, input logic [15:0] val);
        for (int x = 0; x < N * N; x++) begin
            logic [15:0] ad;
            ad = base + 16'(x);
            mem[ad] = use_const ? val : 16'($urandom);
        end
    endtask

    // Runs one complete job; called and returning on a falling edge.
    task automatic run_job(input string tag, input logic [15:0] ba, input logic [15:0] bb,
                           input logic [15:0] bab, input bit sat, input bit rw, input bit poke);
        int n;
        bit seen;
        push_expected(ba, bb, bab, sat);
        rand_wait  = rw;
        waits      = 0;
        proto_errs = 0;
        base_a = ba; base_b = bb; base_ab = bab; sat_mode = sat;
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (poke && n == 50) begin
                start = 1'b1;
                base_a = ~ba; base_b = ~bb; base_ab = ~bab; sat_mode = ~sat;
            end
            if (poke && n == 51) begin
                base_a = ba; base_b = bb; base_ab = bab; sat_mode = sat;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no done in %0d cycles, expected done", tag, n);
        end
        check({tag, "_cycles"}, n, N * N * (4 * N + 2) + 1 + waits);
        check({tag, "_err"}, longint'(err), 0);
        check({tag, "_busy_at_done"}, longint'(busy), 1);
        @(negedge clk);
        check({tag, "_busy_after"}, longint'(busy), 0);
        check({tag, "_done_pulse"}, longint'(done), 0);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_protocol"}, proto_errs, 0);
        $display("[TB] job %s: sat=%0d waits=%0d cycles=%0d", tag, sat, waits, n);
        exp_q.delete();
        rand_wait = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        for (int x = 0; x < 65536; x++) mem[x] = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_err", longint'(err), 0);
        check("rst_rd", longint'(rd), 0);
        check("rst_wr", longint'(wr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Random data, zero-wait and with random wait states
        fill(16'h0100, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("rand_wrap", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0);
        fill(16'h0100, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("rand_sat_waits", 16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b1, 1'b0);
        fill(16'h0100, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("rand_wrap_waits", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b1, 1'b0);

        // Known-answer overflow cases: each element is 4 * (+-200 * 200)
        fill(16'h0100, 1'b1, 16'd200); fill(16'h0200, 1'b1, 16'd200);
        run_job("p200_wrap", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0);
        check("p200_wrap_val", longint'(mem[16'h0300]), 28928);
        run_job("p200_sat", 16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b0, 1'b0);
        check("p200_sat_val", longint'(mem[16'h0305]), 32767);
        fill(16'h0100, 1'b1, 16'hFF38);
        run_job("m200_sat", 16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b0, 1'b0);
        check("m200_sat_val", longint'(mem[16'h030F]), 32768);
        run_job("m200_wrap", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0);
        check("m200_wrap_val", longint'(mem[16'h030A]), 16'h8F00);

        // Address wrap, with a start pulse while busy
        fill(16'hFFFE, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("wrap_poke", 16'hFFFE, 16'h0200, 16'h0300, 1'b0, 1'b1, 1'b1);

        // Timeout: ready never arrives
        stall = 1'b1;
        base_a = 16'h0100; base_b = 16'h0200; base_ab = 16'h0300; sat_mode = 1'b0;
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("to_cycles", n, TO + 1);
        check("to_err", longint'(err), 1);
        check("to_rd", longint'(rd), 0);
        check("to_wr", longint'(wr), 0);
        @(negedge clk);
        check("to_err_sticky", longint'(err), 1);
        check("to_busy_after", longint'(busy), 0);
        $display("[TB] job timeout: cycles=%0d err=%0d", n, err);
        stall = 1'b0;
        fill(16'h0100, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("after_timeout", 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a write
        push_expected(16'h0100, 16'h0200, 16'h0300, 1'b0);
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (wr) seen = 1'b1;
        end
        check("rstwr_reached_wr", longint'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_rd", longint'(rd), 0);
        check("rstwr_wr", longint'(wr), 0);
        check("rstwr_busy", longint'(busy), 0);
        check("rstwr_done", longint'(done), 0);
        $display("[TB] job reset_mid_write: wr seen after %0d cycles", n);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        fill(16'h0100, 1'b0, 16'h0); fill(16'h0200, 1'b0, 16'h0);
        run_job("after_reset", 16'h0100, 16'h0200, 16'h0300, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
